// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - time-multiplexed hex 7-segment scan driver
// Shadowed value/dp/blank, per-slot dead-time, leading-zero suppression, registered pin drive.
module seven_seg_scan #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_en,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an,
    output logic [IDX_W-1:0]      digit_idx
);

    // XOR masks that turn logical "lit/selected" into physical pin levels
    localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{(AN_ACTIVE_LOW != 0)}};

    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   dp_q, dp_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_out_q, dp_out_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic [DIGITS-1:0]   lz_dark;
    logic                upper_zero;
    logic [3:0]          nib;
    logic                dp_sel;
    logic                dark;
    logic                in_slot;
    logic [6:0]          seg_lit;
    logic                dp_lit;
    logic [DIGITS-1:0]   an_lit;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    always_comb begin
        value_d = load ? value : value_q;
        dp_d    = load ? dp    : dp_q;
        blank_d = load ? blank : blank_q;

        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        // A digit is a suppressed leading zero when it and every digit above it are zero
        upper_zero = 1'b1;
        lz_dark    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (value_q[4*i +: 4] == 4'h0);
            lz_dark[i] = lz_en & upper_zero & (i != 0);
        end

        nib    = 4'h0;
        dp_sel = 1'b0;
        dark   = 1'b1;
        an_lit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib       = value_q[4*i +: 4];
                dp_sel    = dp_q[i];
                dark      = blank_q[i] | lz_dark[i];
                an_lit[i] = 1'b1;
            end
        end

        in_slot = (cnt_q >= CNT_W'(BLANK_CYCLES));
        if (!in_slot) begin
            an_lit = '0;
        end
        seg_lit = (in_slot && !dark) ? hex_to_seg(nib) : 7'h00;
        dp_lit  = in_slot & ~dark & dp_sel;

        seg_d    = seg_lit ^ SEG_OFF;
        dp_out_d = dp_lit ^ DP_OFF;
        an_d     = an_lit ^ AN_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q  <= '0;
            dp_q     <= '0;
            blank_q  <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            seg_q    <= SEG_OFF;
            dp_out_q <= DP_OFF;
            an_q     <= AN_OFF;
        end else begin
            value_q  <= value_d;
            dp_q     <= dp_d;
            blank_q  <= blank_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            dp_out_q <= dp_out_d;
            an_q     <= an_d;
        end
    end

    assign seg       = seg_q;
    assign dp_out    = dp_out_q;
    assign an        = an_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - self-checking bench for seven_seg_scan
// A cycle model pushes expected pin states; each clock pops and compares, plus directed spot checks.
module tb_seven_seg_scan;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz_en;
    logic        load;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    always #5 clk = ~clk;

    seven_seg_scan #(
        .DIGITS(DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .SEG_ACTIVE_LOW(1),
        .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .value(value),
        .dp(dp),
        .blank(blank),
        .lz_en(lz_en),
        .load(load),
        .seg(seg),
        .dp_out(dp_out),
        .an(an),
        .digit_idx(digit_idx)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
    } obs_t;

    obs_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_cnt = 0;
    int          m_idx = 0;
    logic [15:0] s_val = '0;
    logic [3:0]  s_dp = '0;
    logic [3:0]  s_blank = '0;
    logic [6:0]  seg_tab [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    function automatic obs_t model_out();
        obs_t o;
        logic dark;
        logic allz;
        o.an  = 4'hF;
        o.seg = 7'h7F;
        o.dp  = 1'b1;
        o.idx = 2'd0;
        if (m_cnt >= BLANK_CYCLES) begin
            o.an = ~(4'b0001 << m_idx);
            dark = s_blank[m_idx];
            if (lz_en && m_idx > 0) begin
                allz = 1'b1;
                for (int k = m_idx; k < DIGITS; k++)
                    if (s_val[4*k +: 4] != 4'h0) allz = 1'b0;
                if (allz) dark = 1'b1;
            end
            if (!dark) begin
                o.seg = ~seg_tab[s_val[4*m_idx +: 4]];
                o.dp  = ~s_dp[m_idx];
            end
        end
        return o;
    endfunction

    task automatic step();
        obs_t e;
        obs_t got;
        if (rst) begin
            e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
            m_cnt = 0; m_idx = 0;
            s_val = '0; s_dp = '0; s_blank = '0;
        end else begin
            e = model_out();
            if (load) begin
                s_val = value; s_dp = dp; s_blank = blank;
            end
            if (m_cnt == SCAN_DIV - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % DIGITS;
            end else begin
                m_cnt++;
            end
        end
        e.idx = m_idx[1:0];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got.an = an; got.seg = seg; got.dp = dp_out; got.idx = digit_idx;
        e = exp_q.pop_front();
        check("scan_model", 32'(got), 32'(e));
    endtask

    task automatic wait_digit(input int d);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (an === ~(4'b0001 << d)) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_digit", 32'(ok), 32'd1);
    endtask

    initial begin
        int dig0_on;
        int all_off;
        int mid_ok;
        logic [6:0] dec_exp [4];

        seg_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
        dec_exp = '{7'b0001110, 7'b0110000, 7'b0001000, 7'b0000000};

        rst = 1'b1; value = '0; dp = '0; blank = '0; lz_en = 1'b0; load = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check("reset_an", 32'(an), 32'hF);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_dp", 32'(dp_out), 32'h1);
        check("reset_idx", 32'(digit_idx), 32'h0);
        rst = 1'b0;

        // one full 32-cycle scan frame: output k reflects slot state k-1
        dig0_on = 0;
        all_off = 0;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (an === 4'b1110) dig0_on++;
            if (an === 4'b1111) all_off++;
            if (k == 3)  check("order_d0", 32'(an), 32'b1110);
            if (k == 11) check("order_d1", 32'(an), 32'b1101);
            if (k == 19) check("order_d2", 32'(an), 32'b1011);
            if (k == 27) check("order_d3", 32'(an), 32'b0111);
            if (k == 9)  check("deadtime", 32'(an), 32'b1111);
        end
        check("d0_active_cycles", 32'(dig0_on), 32'd6);
        check("dead_cycles", 32'(all_off), 32'd8);

        value = 16'h8A3F; dp = 4'b0000; blank = 4'b0000; load = 1'b1;
        step();
        load = 1'b0;
        for (int d = 0; d < 4; d++) begin
            wait_digit(d);
            check("decode_seg", 32'(seg), 32'(dec_exp[d]));
        end

        value = 16'h0050; lz_en = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        wait_digit(3); check("lz_d3_dark", 32'(seg), 32'h7F);
        wait_digit(2); check("lz_d2_dark", 32'(seg), 32'h7F);
        wait_digit(1); check("lz_d1_five", 32'(seg), 32'b0010010);
        wait_digit(0); check("lz_d0_zero", 32'(seg), 32'b1000000);

        value = 16'h0000; load = 1'b1;
        step();
        load = 1'b0;
        wait_digit(1); check("lz0_d1_dark", 32'(seg), 32'h7F);
        wait_digit(0); check("lz0_d0_zero", 32'(seg), 32'b1000000);

        value = 16'h1234; lz_en = 1'b0; blank = 4'b0100; dp = 4'b0110; load = 1'b1;
        step();
        load = 1'b0;
        wait_digit(1); check("dp_d1_lit", 32'(dp_out), 32'h0);
        wait_digit(2); check("blank_d2_seg", 32'(seg), 32'h7F);
        check("blank_d2_dp", 32'(dp_out), 32'h1);
        wait_digit(3); check("dp_d3_off", 32'(dp_out), 32'h1);
        wait_digit(0); check("dp_d0_off", 32'(dp_out), 32'h1);

        // inputs change without load: display must keep the shadow
        value = 16'hFFFF; blank = 4'b0000; dp = 4'b0000;
        for (int k = 0; k < 20; k++) step();
        wait_digit(0); check("shadow_hold", 32'(seg), 32'b0011001);
        load = 1'b1;
        step();
        load = 1'b0;
        check("load_not_yet", 32'(seg), 32'b0011001);
        step();
        check("load_visible", 32'(seg), 32'b0001110);

        mid_ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (m_idx == 2 && m_cnt == 5) begin
                mid_ok = 1;
                break;
            end
            step();
        end
        check("reach_mid_slot", 32'(mid_ok), 32'd1);
        rst = 1'b1;
        step();
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_idx", 32'(digit_idx), 32'h0);
        check("midrst_seg", 32'(seg), 32'h7F);
        rst = 1'b0;
        wait_digit(0);
        check("after_rst_idx", 32'(digit_idx), 32'h0);
        check("after_rst_zero", 32'(seg), 32'b1000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
